// File: rtl/zmem_arb_if.sv
// Shared byte-wide memory bus between the arbiter (master) and the memory (slave).
// Requests are held until mem_ack; read data returns later on mem_rvalid.
interface zmem_arb_if #(
  parameter int ADDR_W = 22
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_fetch;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata, mem_fetch,
    input  mem_ack, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata, mem_fetch,
    output mem_ack, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/zmem_arb.sv
// Z80/DMA arbiter for one shared memory port: CPU has priority, and a starvation
// counter forces a DMA grant after DMA_STARVE consecutive CPU grants.
module zmem_arb #(
  parameter int ADDR_W     = 22,
  parameter int DMA_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic              cpu_fetch,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_wait,
  output logic              cpu_ovf,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  zmem_arb_if.master        mem
);

  typedef enum logic [2:0] {IDLE, C_REQ, C_RD, D_REQ, D_RD} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(DMA_STARVE);

  state_t            state, state_nx;
  logic              pend, p_wr, p_fetch;
  logic [ADDR_W-1:0] p_addr;
  logic [7:0]        p_wdata;
  logic [3:0]        starve;
  logic              grant_c, grant_d, c_fin, d_fin;

  assign cpu_wait = pend | (state == C_REQ) | (state == C_RD);

  // A strobe arriving in IDLE already outranks DMA (unless starved), so the
  // IDLE cycle spent latching it does not let a waiting DMA slip in first.
  always_comb begin
    state_nx = state;
    grant_c  = 1'b0;
    grant_d  = 1'b0;
    c_fin    = 1'b0;
    d_fin    = 1'b0;
    case (state)
      IDLE: begin
        if ((pend | cpu_req) && (!dma_req || (starve < STARVE_LIM))) begin
          if (pend) begin
            grant_c  = 1'b1;
            state_nx = C_REQ;
          end
        end else if (dma_req) begin
          grant_d  = 1'b1;
          state_nx = D_REQ;
        end
      end
      C_REQ: if (mem.mem_ack) begin
        if (mem.mem_wr) begin
          c_fin    = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = C_RD;
        end
      end
      C_RD: if (mem.mem_rvalid) begin
        c_fin    = 1'b1;
        state_nx = IDLE;
      end
      D_REQ: if (mem.mem_ack) begin
        if (mem.mem_wr) begin
          d_fin    = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = D_RD;
        end
      end
      D_RD: if (mem.mem_rvalid) begin
        d_fin    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend          <= 1'b0;
      p_wr          <= 1'b0;
      p_fetch       <= 1'b0;
      p_addr        <= '0;
      p_wdata       <= '0;
      starve        <= '0;
      cpu_rdata     <= '0;
      cpu_done      <= 1'b0;
      cpu_ovf       <= 1'b0;
      dma_ack       <= 1'b0;
      dma_rdata     <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_fetch <= 1'b0;
    end else begin
      if (cpu_req && !pend) begin
        pend    <= 1'b1;
        p_wr    <= cpu_wr;
        p_fetch <= cpu_fetch;
        p_addr  <= cpu_addr;
        p_wdata <= cpu_wdata;
      end else if (c_fin) begin
        pend <= 1'b0;
      end
      if (cpu_req && pend) cpu_ovf <= 1'b1;

      cpu_done <= c_fin;
      dma_ack  <= d_fin;
      if (c_fin && (state == C_RD)) cpu_rdata <= mem.mem_rdata;
      if (d_fin && (state == D_RD)) dma_rdata <= mem.mem_rdata;

      if (grant_c) begin
        mem.mem_req   <= 1'b1;
        mem.mem_wr    <= p_wr;
        mem.mem_addr  <= p_addr;
        mem.mem_wdata <= p_wdata;
        mem.mem_fetch <= p_fetch;
        starve        <= dma_req ? starve + 4'd1 : 4'd0;
      end else if (grant_d) begin
        mem.mem_req   <= 1'b1;
        mem.mem_wr    <= dma_wr;
        mem.mem_addr  <= dma_addr;
        mem.mem_wdata <= dma_wdata;
        mem.mem_fetch <= 1'b0;
        starve        <= '0;
      end else if (mem.mem_req && mem.mem_ack) begin
        mem.mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zmem_arb.sv
// Directed bench for zmem_arb: stimulus queues expected bus accesses and completions,
// a forked monitor pops and compares them as the DUT presents them.
module tb_zmem_arb;
  localparam int AW = 22;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          cpu_req = 1'b0, cpu_wr = 1'b0, cpu_fetch = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic [7:0]    cpu_rdata;
  logic          cpu_done, cpu_wait, cpu_ovf;
  logic          dma_req = 1'b0, dma_wr = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [7:0]    dma_wdata = '0;
  logic          dma_ack;
  logic [7:0]    dma_rdata;

  logic          ack_en = 1'b1;
  logic [7:0]    rd_val = '0;
  int            rd_lat = 1;
  int            n_chk = 0, n_fail = 0;

  logic [AW+9:0] bus_q[$];
  logic [8:0]    cpu_q[$];
  logic [8:0]    dma_q[$];

  zmem_arb_if #(.ADDR_W(AW)) mif ();

  zmem_arb #(.ADDR_W(AW), .DMA_STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_fetch(cpu_fetch), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_wait(cpu_wait), .cpu_ovf(cpu_ovf),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem(mif)
  );

  assign mif.mem_ack = ack_en;
  always #5 clk = ~clk;

  // Memory read responder: rvalid arrives rd_lat edges after the accepting edge.
  initial begin
    int rv_timer;
    rv_timer = 0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mif.mem_req && mif.mem_ack && !mif.mem_wr) rv_timer = rd_lat;
      @(posedge clk);
      #1;
      mif.mem_rvalid = 1'b0;
      if (rv_timer > 0) begin
        rv_timer--;
        if (rv_timer == 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = rd_val;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected / not seen at %0t", nm, $time);
  endtask

  function automatic logic [AW+9:0] bus_e(input logic wr, input logic fetch,
                                          input logic [AW-1:0] a, input logic [7:0] d);
    return {wr, fetch, a, d};
  endfunction

  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mif.mem_req && mif.mem_ack) begin
          if (bus_q.size() == 0) fail_now("bus_unexpected");
          else check("bus_access",
                     64'({mif.mem_wr, mif.mem_fetch, mif.mem_addr, mif.mem_wdata}),
                     64'(bus_q.pop_front()));
        end
        if (cpu_done) begin
          if (cpu_q.size() == 0) fail_now("cpu_done_unexpected");
          else begin
            e = cpu_q.pop_front();
            if (e[8]) check("cpu_rdata", 64'(cpu_rdata), 64'(e[7:0]));
          end
        end
        if (dma_ack) begin
          if (dma_q.size() == 0) fail_now("dma_ack_unexpected");
          else begin
            e = dma_q.pop_front();
            if (e[8]) check("dma_rdata", 64'(dma_rdata), 64'(e[7:0]));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic wr, input logic fetch, input logic [AW-1:0] a,
                        input logic [7:0] d);
    cpu_wr = wr; cpu_fetch = fetch; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_cpu_done(input string nm, input logic chk_wait);
    int k;
    k = 0;
    while (!cpu_done && k < 30) begin
      if (chk_wait) check({nm, "_wait_held"}, 64'(cpu_wait), 64'(1));
      tick();
      k++;
    end
    if (!cpu_done) fail_now({nm, "_timeout"});
  endtask

  task automatic wait_dma_ack(input string nm);
    int k;
    k = 0;
    while (!dma_ack && k < 30) begin
      tick();
      k++;
    end
    if (!dma_ack) fail_now({nm, "_timeout"});
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset
    #1 rst_n = 1'b0;
    #2;
    check("rst_mem_req", 64'(mif.mem_req), 64'(0));
    check("rst_cpu_wait", 64'(cpu_wait), 64'(0));
    check("rst_outs", 64'({cpu_done, cpu_ovf, dma_ack, cpu_rdata, dma_rdata}), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // CPU write, ack tied high
    bus_q.push_back(bus_e(1'b1, 1'b0, 22'h012345, 8'hA5));
    cpu_q.push_back(9'h000);
    strobe(1'b1, 1'b0, 22'h012345, 8'hA5);
    check("wr_e0_wait", 64'(cpu_wait), 64'(1));
    check("wr_e0_req", 64'(mif.mem_req), 64'(0));
    tick();
    check("wr_e1_req", 64'({mif.mem_req, mif.mem_wr}), 64'(3));
    check("wr_e1_wait_done", 64'({cpu_wait, cpu_done}), 64'(2));
    tick();
    check("wr_e2_done", 64'({cpu_done, cpu_wait, mif.mem_req}), 64'(4));
    tick();
    check("wr_e3_done_pulse", 64'(cpu_done), 64'(0));

    // Opcode fetch, read latency 2
    rd_lat = 2; rd_val = 8'h3E;
    bus_q.push_back(bus_e(1'b0, 1'b1, 22'h000100, 8'h00));
    cpu_q.push_back({1'b1, 8'h3E});
    strobe(1'b0, 1'b1, 22'h000100, 8'h00);
    wait_cpu_done("fetch", 1'b1);
    check("fetch_rdata", 64'(cpu_rdata), 64'(8'h3E));
    check("fetch_wait_low", 64'(cpu_wait), 64'(0));
    tick();

    // Simultaneous CPU and DMA requests; DMA stalled on the bus
    dma_wr = 1'b1; dma_addr = 22'h3ABCDE; dma_wdata = 8'h77; dma_req = 1'b1;
    bus_q.push_back(bus_e(1'b1, 1'b0, 22'h000200, 8'h11));
    bus_q.push_back(bus_e(1'b1, 1'b0, 22'h3ABCDE, 8'h77));
    cpu_q.push_back(9'h000);
    dma_q.push_back(9'h000);
    strobe(1'b1, 1'b0, 22'h000200, 8'h11);
    check("arb_hold", 64'(mif.mem_req), 64'(0));
    tick();
    check("arb_cpu_first", 64'(mif.mem_addr), 64'(22'h000200));
    wait_cpu_done("arb_cpu", 1'b0);
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dma_stall_bus", 64'({mif.mem_req, mif.mem_wr, mif.mem_fetch, mif.mem_addr, mif.mem_wdata}),
            64'({3'b110, 22'h3ABCDE, 8'h77}));
      check("dma_stall_noack", 64'(dma_ack), 64'(0));
    end
    ack_en = 1'b1;
    tick();
    check("dma_ack_pulse", 64'(dma_ack), 64'(1));
    dma_req = 1'b0;
    tick();
    check("dma_ack_once", 64'({dma_ack, mif.mem_req}), 64'(0));
    tick();
    check("dma_idle", 64'(mif.mem_req), 64'(0));

    // Starvation: DMA held, CPU re-strobes after every cpu_done
    rd_lat = 1; rd_val = 8'hC4;
    dma_wr = 1'b0; dma_addr = 22'h000ABC; dma_wdata = 8'h00;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        bus_q.push_back(bus_e(1'b1, 1'b0, 22'(32'h10 + 4 * r + i), 8'(8'h20 + 4 * r + i)));
        cpu_q.push_back(9'h000);
      end
      bus_q.push_back(bus_e(1'b0, 1'b0, 22'h000ABC, 8'h00));
      dma_q.push_back({1'b1, 8'hC4});
    end
    dma_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, 1'b0, 22'(32'h10 + i), 8'(8'h20 + i));
      wait_cpu_done("starve_cpu", 1'b0);
    end
    wait_dma_ack("starve_dma");
    dma_req = 1'b0;
    check("starve_dma_rdata", 64'(dma_rdata), 64'(8'hC4));
    repeat (3) tick();
    check("starve_bus_q_empty", 64'(bus_q.size()), 64'(0));
    check("starve_dma_q_empty", 64'(dma_q.size()), 64'(0));

    // Overflow: second strobe while first read is in C_RD
    rd_lat = 3; rd_val = 8'h5C;
    bus_q.push_back(bus_e(1'b0, 1'b0, 22'h000300, 8'h00));
    cpu_q.push_back({1'b1, 8'h5C});
    check("ovf_clear_before", 64'(cpu_ovf), 64'(0));
    strobe(1'b0, 1'b0, 22'h000300, 8'h00);
    tick();
    tick();
    check("ovf_c_rd_req_low", 64'({mif.mem_req, cpu_wait}), 64'(1));
    strobe(1'b1, 1'b0, 22'h000400, 8'hEE);
    check("ovf_set", 64'(cpu_ovf), 64'(1));
    wait_cpu_done("ovf_read", 1'b0);
    check("ovf_read_data", 64'(cpu_rdata), 64'(8'h5C));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ovf_no_extra", 64'({mif.mem_req, cpu_wait, cpu_ovf}), 64'(1));
    end

    // Reset in the middle of a DMA read
    rd_lat = 4; rd_val = 8'h99;
    dma_wr = 1'b0; dma_addr = 22'h155555; dma_wdata = 8'h00; dma_req = 1'b1;
    bus_q.push_back(bus_e(1'b0, 1'b0, 22'h155555, 8'h00));
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    dma_req = 1'b0;
    #1;
    check("mid_rst_mem", 64'({mif.mem_req, mif.mem_wr, mif.mem_fetch, mif.mem_addr, mif.mem_wdata}),
          64'(0));
    check("mid_rst_cpu", 64'({cpu_done, cpu_wait, cpu_ovf, cpu_rdata}), 64'(0));
    check("mid_rst_dma", 64'({dma_ack, dma_rdata}), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_quiet", 64'({dma_ack, mif.mem_req, cpu_done, dma_rdata}), 64'(0));
    end

    check("end_bus_q_empty", 64'(bus_q.size()), 64'(0));
    check("end_cpu_q_empty", 64'(cpu_q.size()), 64'(0));
    check("end_dma_q_empty", 64'(dma_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
